// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-button 2-flop synchroniser, debounce with
// registered level, one-cycle press/release strobes, and masked auto-repeat.

// One button: sync -> debounce -> repeat FSM, all outputs registered.
module btn_conditioner_lane #(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int REPEAT_DELAY = 4000000,
  parameter int REPEAT_RATE  = 1250000,
  parameter bit REPEAT_EN    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DCW  = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYC - 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RR_LAST = RCW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} state_t;

  logic           s1_q, s2_q;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           acc_rise, acc_fall;
  state_t         state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic           rep_fire;

  // Synchroniser, debounce state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Debounce: accept s2 only after DEBOUNCE_CYC consecutive differing cycles.
  always_comb begin
    dcnt_d   = dcnt_q;
    level_d  = level_q;
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    if (s2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DC_LAST) begin
      dcnt_d   = '0;
      level_d  = s2_q;
      acc_rise = s2_q;
      acc_fall = ~s2_q;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Repeat FSM next state; an accepted release always wins.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (acc_rise && REPEAT_EN) begin
          state_d = DELAY;
          rcnt_d  = '0;
        end
      end
      DELAY: begin
        if (rcnt_q == RD_LAST) begin
          state_d = RPT;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RPT: begin
        if (rcnt_q == RR_LAST) rcnt_d = '0;
        else                   rcnt_d = rcnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
    if (acc_fall) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end
  end

  // Repeat FSM output: tick at the end of each delay/rate period unless released.
  always_comb begin
    rep_fire = 1'b0;
    if ((state_q == DELAY && rcnt_q == RD_LAST) || (state_q == RPT && rcnt_q == RR_LAST))
      rep_fire = ~acc_fall;
  end

  // Strobe next-state: press edge or repeat tick, release edge.
  always_comb begin
    press_d   = acc_rise | rep_fire;
    release_d = acc_fall;
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule

// Top: array of independent per-button lanes.
module btn_conditioner #(
  parameter int               N_BTN        = 5,
  parameter int               DEBOUNCE_CYC = 250000,
  parameter int               REPEAT_DELAY = 4000000,
  parameter int               REPEAT_RATE  = 1250000,
  parameter logic [N_BTN-1:0] REPEAT_MASK  = 5'b01110
) (
  input  logic             CLK25M,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE
);
  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    btn_conditioner_lane #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_EN   (REPEAT_MASK[g])
    ) u_lane (
      .clk_i    (CLK25M),
      .rst_ni   (RST_N),
      .raw_i    (BTN_IN[g]),
      .level_o  (BTN_LEVEL[g]),
      .press_o  (BTN_PRESS[g]),
      .release_o(BTN_RELEASE[g])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYC=4, REPEAT_DELAY=10,
// REPEAT_RATE=3. Each table row drives BTN_IN and holds it for 'hold'
// cycles; the intermediate cycles must show no strobes and the last cycle
// must match the row's level/press/release exactly.
module tb_btn_conditioner;
  logic       CLK25M = 1'b0;
  logic       RST_N;
  logic [4:0] BTN_IN;
  logic [4:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0] btn;
    int         hold;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
  } seg_t;

  seg_t tbl[$];

  btn_conditioner #(
    .N_BTN(5), .DEBOUNCE_CYC(4), .REPEAT_DELAY(10), .REPEAT_RATE(3),
    .REPEAT_MASK(5'b01110)
  ) dut (
    .CLK25M(CLK25M), .RST_N(RST_N), .BTN_IN(BTN_IN),
    .BTN_LEVEL(BTN_LEVEL), .BTN_PRESS(BTN_PRESS), .BTN_RELEASE(BTN_RELEASE)
  );

  always #5 CLK25M = ~CLK25M;

  task automatic chk(input string nm, input int id, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s seg %0d: got %b want %b", nm, id, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] b, input int h, input logic [4:0] l, input logic [4:0] p, input logic [4:0] r);
    seg_t s;
    s.btn = b; s.hold = h; s.lvl = l; s.prs = p; s.rel = r;
    tbl.push_back(s);
  endtask

  // Called at a negedge; drives BTN_IN and checks each following cycle.
  task automatic run_seg(input logic [4:0] b, input int hold, input logic [4:0] l,
                         input logic [4:0] p, input logic [4:0] r, input int id);
    BTN_IN = b;
    for (int k = 1; k <= hold; k++) begin
      @(posedge CLK25M);
      @(negedge CLK25M);
      if (k < hold) begin
        chk("quiet", id, {BTN_PRESS, BTN_RELEASE}, 10'b0);
      end else begin
        chk("level",   id, {5'b0, BTN_LEVEL},   {5'b0, l});
        chk("press",   id, {5'b0, BTN_PRESS},   {5'b0, p});
        chk("release", id, {5'b0, BTN_RELEASE}, {5'b0, r});
      end
    end
  endtask

  initial begin
    // idle after reset
    add(5'b00000, 3, 5'b00000, 5'b00000, 5'b00000);
    // glitch on U: 3 cycles high never reaches the 4-cycle threshold
    add(5'b00001, 3, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00000, 10, 5'b00000, 5'b00000, 5'b00000);
    // bounce on C, then held: one press 6 cycles after final rise, no repeats
    add(5'b10000, 2, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00000, 2, 5'b00000, 5'b00000, 5'b00000);
    add(5'b10000, 2, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00000, 2, 5'b00000, 5'b00000, 5'b00000);
    add(5'b10000, 6, 5'b10000, 5'b10000, 5'b00000);
    add(5'b10000, 20, 5'b10000, 5'b00000, 5'b00000);
    add(5'b00000, 6, 5'b00000, 5'b00000, 5'b10000);
    add(5'b00000, 4, 5'b00000, 5'b00000, 5'b00000);
    // L held 40 cycles: press @6, repeats @16,19..40,43; release @46 hits a tick
    add(5'b00010, 6, 5'b00010, 5'b00010, 5'b00000);
    add(5'b00010, 10, 5'b00010, 5'b00010, 5'b00000);
    for (int i = 0; i < 8; i++) add(5'b00010, 3, 5'b00010, 5'b00010, 5'b00000);
    add(5'b00000, 3, 5'b00010, 5'b00010, 5'b00000);
    add(5'b00000, 3, 5'b00000, 5'b00000, 5'b00010);
    add(5'b00000, 12, 5'b00000, 5'b00000, 5'b00000);
    // R released during the initial delay: no repeat ever
    add(5'b00100, 6, 5'b00100, 5'b00100, 5'b00000);
    add(5'b00100, 2, 5'b00100, 5'b00000, 5'b00000);
    add(5'b00000, 6, 5'b00000, 5'b00000, 5'b00100);
    add(5'b00000, 12, 5'b00000, 5'b00000, 5'b00000);
    // L then R two cycles later: independent cadences (L 16,19.. R 18,21..)
    add(5'b00010, 2, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00110, 4, 5'b00010, 5'b00010, 5'b00000);
    add(5'b00110, 2, 5'b00110, 5'b00100, 5'b00000);
    add(5'b00110, 8, 5'b00110, 5'b00010, 5'b00000);
    add(5'b00110, 2, 5'b00110, 5'b00100, 5'b00000);
    add(5'b00110, 1, 5'b00110, 5'b00010, 5'b00000);
    add(5'b00110, 2, 5'b00110, 5'b00100, 5'b00000);
    add(5'b00110, 1, 5'b00110, 5'b00010, 5'b00000);
    add(5'b00110, 2, 5'b00110, 5'b00100, 5'b00000);
    // both released; R's tick @30 coincides with the release
    add(5'b00000, 1, 5'b00110, 5'b00010, 5'b00000);
    add(5'b00000, 2, 5'b00110, 5'b00100, 5'b00000);
    add(5'b00000, 1, 5'b00110, 5'b00010, 5'b00000);
    add(5'b00000, 2, 5'b00000, 5'b00000, 5'b00110);
    add(5'b00000, 10, 5'b00000, 5'b00000, 5'b00000);

    RST_N  = 1'b0;
    BTN_IN = 5'b00000;
    #12;
    chk("rst_level",   -1, {5'b0, BTN_LEVEL},   10'b0);
    chk("rst_press",   -1, {5'b0, BTN_PRESS},   10'b0);
    chk("rst_release", -1, {5'b0, BTN_RELEASE}, 10'b0);
    @(negedge CLK25M);
    RST_N = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run_seg(tbl[i].btn, tbl[i].hold, tbl[i].lvl, tbl[i].prs, tbl[i].rel, i);

    // D held into REPEAT; reset while the first repeat strobe is visible
    run_seg(5'b01000, 6,  5'b01000, 5'b01000, 5'b00000, 100);
    run_seg(5'b01000, 10, 5'b01000, 5'b01000, 5'b00000, 101);
    RST_N = 1'b0;
    #1;
    chk("async_rst", 102, {BTN_LEVEL, BTN_PRESS}, 10'b0);
    chk("async_rst_rel", 102, {5'b0, BTN_RELEASE}, 10'b0);
    @(posedge CLK25M);
    @(negedge CLK25M);
    chk("rst_hold", 103, {BTN_LEVEL, BTN_PRESS | BTN_RELEASE}, 10'b0);
    RST_N = 1'b1;
    // button still held: fresh press 6 cycles later, then a clean repeat run
    run_seg(5'b01000, 6,  5'b01000, 5'b01000, 5'b00000, 104);
    run_seg(5'b01000, 10, 5'b01000, 5'b01000, 5'b00000, 105);
    run_seg(5'b00000, 3,  5'b01000, 5'b01000, 5'b00000, 106);
    run_seg(5'b00000, 3,  5'b00000, 5'b00000, 5'b01000, 107);
    run_seg(5'b00000, 8,  5'b00000, 5'b00000, 5'b00000, 108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
